// File: rtl/bip_defs.sv
// Shared definitions for the BIP program loader: default widths, frame byte order and FSM states.
package bip_defs;

  localparam int unsigned NB_INSTRUCTION_DEF = 16;
  localparam int unsigned NB_ADDR_DEF        = 11;
  localparam int unsigned NB_BYTE_DEF        = 8;

  // Each instruction arrives low byte first.
  localparam bit FRAME_LITTLE_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
    ST_RUN
  } state_t;

  // Combine two bytes in arrival order into one instruction word.
  function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
    return FRAME_LITTLE_ENDIAN ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/bip_loader_timeout.sv
// Inter-byte idle counter; flags expiry when the count reaches its limit while enabled.
module bip_loader_timeout #(
  parameter int unsigned NB_TIMEOUT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam logic [NB_TIMEOUT-1:0] LIMIT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + NB_TIMEOUT'(1);
    end
  end

  // A byte arriving in the same cycle wins over expiry.
  assign expired_c = enable && !clear && (count_q == LIMIT);

endmodule

// File: rtl/bip_program_loader.sv
// Assembles UART bytes into instructions, writes them to program memory and gates CPU reset.
module bip_program_loader
  import bip_defs::*;
#(
  parameter int unsigned NB_INSTRUCTION = NB_INSTRUCTION_DEF,
  parameter int unsigned NB_ADDR        = NB_ADDR_DEF,
  parameter int unsigned NB_BYTE        = NB_BYTE_DEF,
  parameter int unsigned NB_TIMEOUT     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_cpu_halt,
  output logic                      o_prog_wr_enable,
  output logic [NB_ADDR-1:0]        o_prog_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_prog_wr_data,
  output logic                      o_cpu_reset,
  output logic                      o_busy,
  output logic                      o_load_error
);

  localparam int unsigned NB_COUNT = 2 * NB_BYTE;
  localparam int unsigned DEPTH    = 2 ** NB_ADDR;

  state_t state_q, state_next;

  logic [NB_BYTE-1:0]        cnt_lo_q;
  logic [NB_BYTE-1:0]        low_q;
  logic [NB_COUNT-1:0]       word_count_q;
  logic [NB_ADDR-1:0]        addr_q;
  logic [NB_INSTRUCTION-1:0] word_q;

  logic [NB_COUNT-1:0] count_new_c;
  logic                count_bad_c;
  logic                last_word_c;
  logic                ld_cnt_lo_c, ld_count_c, ld_low_c, ld_word_c;
  logic                clr_addr_c, inc_addr_c, set_err_c, clr_err_c;
  logic                tmo_clear_c, tmo_enable_c, tmo_expired_c;

  assign count_new_c  = {i_rx_data, cnt_lo_q};
  assign count_bad_c  = (count_new_c == '0) || (32'(count_new_c) > DEPTH);
  assign last_word_c  = (NB_COUNT'(addr_q) == (word_count_q - NB_COUNT'(1)));
  assign tmo_enable_c = (state_q == ST_CNT_HI) || (state_q == ST_DATA_LO) || (state_q == ST_DATA_HI);
  assign tmo_clear_c  = i_rx_valid || (state_q == ST_IDLE) || (state_q == ST_RUN);

  bip_loader_timeout #(
    .NB_TIMEOUT    (NB_TIMEOUT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (i_clock),
    .rst_n    (i_reset),
    .clear    (tmo_clear_c),
    .enable   (tmo_enable_c),
    .expired_c(tmo_expired_c)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next  = state_q;
    ld_cnt_lo_c = 1'b0;
    ld_count_c  = 1'b0;
    ld_low_c    = 1'b0;
    ld_word_c   = 1'b0;
    clr_addr_c  = 1'b0;
    inc_addr_c  = 1'b0;
    set_err_c   = 1'b0;
    clr_err_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          ld_cnt_lo_c = 1'b1;
          clr_err_c   = 1'b1;
          state_next  = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (i_rx_valid) begin
          if (count_bad_c) begin
            set_err_c  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            ld_count_c = 1'b1;
            clr_addr_c = 1'b1;
            state_next = ST_DATA_LO;
          end
        end else if (tmo_expired_c) begin
          set_err_c  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DATA_LO: begin
        if (i_rx_valid) begin
          ld_low_c   = 1'b1;
          state_next = ST_DATA_HI;
        end else if (tmo_expired_c) begin
          set_err_c  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DATA_HI: begin
        if (i_rx_valid) begin
          ld_word_c  = 1'b1;
          state_next = ST_WRITE;
        end else if (tmo_expired_c) begin
          set_err_c  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // A byte arriving during the write becomes the next low byte unless the frame is done.
        if (last_word_c) begin
          state_next = ST_RUN;
        end else begin
          inc_addr_c = 1'b1;
          if (i_rx_valid) begin
            ld_low_c   = 1'b1;
            state_next = ST_DATA_HI;
          end else begin
            state_next = ST_DATA_LO;
          end
        end
      end
      ST_RUN: begin
        if (i_cpu_halt) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath and outputs, registered from the next state so they line up with the FSM.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_lo_q         <= '0;
      low_q            <= '0;
      word_count_q     <= '0;
      addr_q           <= '0;
      word_q           <= '0;
      o_prog_wr_enable <= 1'b0;
      o_cpu_reset      <= 1'b1;
      o_busy           <= 1'b0;
      o_load_error     <= 1'b0;
    end else begin
      if (ld_cnt_lo_c) cnt_lo_q <= i_rx_data;
      if (ld_count_c)  word_count_q <= count_new_c;
      if (ld_low_c)    low_q <= i_rx_data;
      if (ld_word_c)   word_q <= NB_INSTRUCTION'(pack_word(low_q, i_rx_data));
      if (clr_addr_c) begin
        addr_q <= '0;
      end else if (inc_addr_c) begin
        addr_q <= addr_q + NB_ADDR'(1);
      end
      if (set_err_c) begin
        o_load_error <= 1'b1;
      end else if (clr_err_c) begin
        o_load_error <= 1'b0;
      end
      o_prog_wr_enable <= (state_next == ST_WRITE);
      o_cpu_reset      <= (state_next != ST_RUN);
      o_busy           <= (state_next == ST_CNT_HI) || (state_next == ST_DATA_LO) ||
                          (state_next == ST_DATA_HI) || (state_next == ST_WRITE);
    end
  end

  assign o_prog_wr_addr = addr_q;
  assign o_prog_wr_data = word_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Scoreboard bench for bip_program_loader: expected writes queued by stimulus, checked by a monitor.
module tb_bip_program_loader;

  localparam int unsigned T_CYC = 100;

  logic        i_clock;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_cpu_halt;
  logic        o_prog_wr_enable;
  logic [10:0] o_prog_wr_addr;
  logic [15:0] o_prog_wr_data;
  logic        o_cpu_reset;
  logic        o_busy;
  logic        o_load_error;

  int total    = 0;
  int bad      = 0;
  int n_writes = 0;
  int w0       = 0;

  logic [26:0] exp_q[$];
  logic [26:0] mon_exp;
  logic [7:0]  frame[$];

  bip_program_loader #(
    .NB_INSTRUCTION(16),
    .NB_ADDR       (11),
    .NB_BYTE       (8),
    .NB_TIMEOUT    (16),
    .TIMEOUT_CYCLES(T_CYC)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_rx_data       (i_rx_data),
    .i_rx_valid      (i_rx_valid),
    .i_cpu_halt      (i_cpu_halt),
    .o_prog_wr_enable(o_prog_wr_enable),
    .o_prog_wr_addr  (o_prog_wr_addr),
    .o_prog_wr_data  (o_prog_wr_data),
    .o_cpu_reset     (o_cpu_reset),
    .o_busy          (o_busy),
    .o_load_error    (o_load_error)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  // Drive the queued frame; b2b keeps i_rx_valid high every cycle.
  task automatic send_frame(input bit b2b);
    for (int i = 0; i < frame.size(); i++) begin
      i_rx_data  = frame[i];
      i_rx_valid = 1'b1;
      @(posedge i_clock);
      #1;
      i_rx_valid = 1'b0;
      if (!b2b && (i != frame.size() - 1)) begin
        @(posedge i_clock);
        #1;
      end
    end
    frame.delete();
  endtask

  task automatic expect_write(input logic [10:0] addr, input logic [15:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge i_clock) begin
    if (o_prog_wr_enable === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write",
                 o_prog_wr_addr, o_prog_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", 32'({o_prog_wr_addr, o_prog_wr_data}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset    = 1'b0;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    i_cpu_halt = 1'b0;

    // Reset state
    cycles(3);
    check("rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("rst_wr_enable", 32'(o_prog_wr_enable), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_load_error", 32'(o_load_error), 32'd0);
    i_reset = 1'b1;
    cycles(1);

    // Three-word load with release latency
    w0 = n_writes;
    expect_write(11'd0, 16'h0801);
    expect_write(11'd1, 16'h1002);
    expect_write(11'd2, 16'h0000);
    frame = '{8'h03, 8'h00, 8'h01, 8'h08, 8'h02, 8'h10, 8'h00, 8'h00};
    send_frame(1'b0);
    check("t2_cpu_held_during_write", 32'(o_cpu_reset), 32'd1);
    check("t2_busy_during_write", 32'(o_busy), 32'd1);
    cycles(1);
    check("t2_cpu_released", 32'(o_cpu_reset), 32'd0);
    check("t2_busy_in_run", 32'(o_busy), 32'd0);
    check("t2_write_count", 32'(n_writes - w0), 32'd3);

    // RUN ignores bytes; halt re-arms; reload from address 0
    w0 = n_writes;
    frame = '{8'h55};
    send_frame(1'b0);
    cycles(2);
    check("t3_run_ignores_rx", 32'(o_cpu_reset), 32'd0);
    check("t3_run_no_write", 32'(n_writes - w0), 32'd0);
    i_cpu_halt = 1'b1;
    cycles(1);
    i_cpu_halt = 1'b0;
    check("t3_halt_cpu_reset", 32'(o_cpu_reset), 32'd1);
    check("t3_halt_not_busy", 32'(o_busy), 32'd0);
    expect_write(11'd0, 16'h1234);
    frame = '{8'h01, 8'h00, 8'h34, 8'h12};
    send_frame(1'b0);
    cycles(1);
    check("t3_reload_run", 32'(o_cpu_reset), 32'd0);
    i_cpu_halt = 1'b1;
    cycles(1);
    i_cpu_halt = 1'b0;

    // Illegal counts and the largest legal count
    w0 = n_writes;
    frame = '{8'h00, 8'h00};
    send_frame(1'b0);
    check("t4_zero_error", 32'(o_load_error), 32'd1);
    check("t4_zero_idle", 32'(o_busy), 32'd0);
    frame = '{8'h01, 8'h08};
    send_frame(1'b0);
    check("t4_over_error", 32'(o_load_error), 32'd1);
    check("t4_over_idle", 32'(o_busy), 32'd0);
    check("t4_over_cpu_held", 32'(o_cpu_reset), 32'd1);
    cycles(2);
    check("t4_no_write", 32'(n_writes - w0), 32'd0);
    frame = '{8'h00, 8'h08};
    send_frame(1'b0);
    check("t4_max_busy", 32'(o_busy), 32'd1);
    check("t4_max_error_cleared", 32'(o_load_error), 32'd0);
    i_reset = 1'b0;
    cycles(1);
    i_reset = 1'b1;
    cycles(1);

    // Timeout after one word
    w0 = n_writes;
    expect_write(11'd0, 16'h2211);
    frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame(1'b0);
    cycles(int'(T_CYC) - 5);
    check("t5_still_loading", 32'(o_busy), 32'd1);
    check("t5_no_error_yet", 32'(o_load_error), 32'd0);
    for (int k = 0; k < 20 && o_busy; k++) cycles(1);
    check("t5_timeout_idle", 32'(o_busy), 32'd0);
    check("t5_timeout_error", 32'(o_load_error), 32'd1);
    check("t5_cpu_held", 32'(o_cpu_reset), 32'd1);
    check("t5_one_write", 32'(n_writes - w0), 32'd1);

    // Back-to-back bytes
    w0 = n_writes;
    expect_write(11'd0, 16'hB1A1);
    expect_write(11'd1, 16'hB2A2);
    expect_write(11'd2, 16'hB3A3);
    expect_write(11'd3, 16'hB4A4);
    frame = '{8'h04, 8'h00, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3, 8'hA4, 8'hB4};
    send_frame(1'b1);
    cycles(2);
    check("t6_b2b_run", 32'(o_cpu_reset), 32'd0);
    check("t6_b2b_writes", 32'(n_writes - w0), 32'd4);
    i_cpu_halt = 1'b1;
    cycles(1);
    i_cpu_halt = 1'b0;

    // Reset while the first write strobe is up, then a clean reload
    w0 = n_writes;
    frame = '{8'h03, 8'h00, 8'h01, 8'h02};
    send_frame(1'b1);
    check("t6_strobe_before_reset", 32'(o_prog_wr_enable), 32'd1);
    i_reset = 1'b0;
    #1;
    check("t6_strobe_cut", 32'(o_prog_wr_enable), 32'd0);
    check("t6_reset_idle", 32'(o_busy), 32'd0);
    check("t6_reset_cpu_held", 32'(o_cpu_reset), 32'd1);
    cycles(1);
    i_reset = 1'b1;
    cycles(1);
    expect_write(11'd0, 16'hABCD);
    frame = '{8'h01, 8'h00, 8'hCD, 8'hAB};
    send_frame(1'b1);
    cycles(1);
    check("t6_reload_run", 32'(o_cpu_reset), 32'd0);
    check("t6_reload_writes", 32'(n_writes - w0), 32'd1);

    cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
